// File: rtl/framebuffer_store_if.sv
// -----------------------------------------------------------------------------
// framebuffer_store_if
//
// Bundles the byte-stream input and the framebuffer RAM write port of
// framebuffer_store.
//
// Handshake: a byte transfers on a rising clk_in edge where byte_valid and
// byte_ready are both 1. The source holds byte_in/byte_valid stable while
// byte_ready is 0; byte_valid may be dropped at any time when no transfer is
// wanted.
//
// Signals
//   byte_in          8   data byte from the host receiver
//   byte_valid       1   byte_in holds a byte this cycle
//   byte_ready       1   block accepts a byte this cycle
//   frame_start      1   synchronous restart of the pixel pointer
//   ram_address      AW  RAM write address {half, row, ~column}
//   ram_data_out     16  RGB565 word
//   ram_write_enable 1   write strobe
//   ram_clk_enable   1   write-port clock enable
//   ram_reset        1   copy of the block reset
//   frame_done       1   pulse with the write of the last pixel
//   pixel_index      AW  index of the next pixel to be written
//
// Modports: master = byte source / observer, slave = framebuffer_store.
// -----------------------------------------------------------------------------
interface framebuffer_store_if #(
  parameter int COLUMN_BITS = 6,
  parameter int ROW_BITS    = 4
);
  localparam int AW = 1 + ROW_BITS + COLUMN_BITS;

  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          frame_start;
  logic [AW-1:0] ram_address;
  logic [15:0]   ram_data_out;
  logic          ram_write_enable;
  logic          ram_clk_enable;
  logic          ram_reset;
  logic          frame_done;
  logic [AW-1:0] pixel_index;

  modport master (
    output byte_in,
    output byte_valid,
    output frame_start,
    input  byte_ready,
    input  ram_address,
    input  ram_data_out,
    input  ram_write_enable,
    input  ram_clk_enable,
    input  ram_reset,
    input  frame_done,
    input  pixel_index
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    input  frame_start,
    output byte_ready,
    output ram_address,
    output ram_data_out,
    output ram_write_enable,
    output ram_clk_enable,
    output ram_reset,
    output frame_done,
    output pixel_index
  );
endinterface

// File: rtl/framebuffer_store.sv
// -----------------------------------------------------------------------------
// framebuffer_store
//
// Writer side of the LED panel framebuffer RAM. Assembles pairs of bytes into
// RGB565 words and writes them at {half, row, ~column} derived from a running
// pixel pointer, matching the layout the display fetch path reads.
//
// Ports
//   clk_in     system clock, all logic on its rising edge
//   reset      asynchronous, active-high reset
//   bus        framebuffer_store_if.slave: byte stream in, RAM write port out
//   fsm_state  current FSM state (0 = ST_HIGH, 1 = ST_LOW, 2 = ST_WRITE)
//
// Configuration
//   FRAMEBUFFER_STORE_LITTLE_ENDIAN_EN  defined: first byte of a pixel is the
//   low byte. Undefined (default): first byte is the high byte.
// -----------------------------------------------------------------------------
module framebuffer_store #(
  parameter int COLUMN_BITS = 6,
  parameter int ROW_BITS    = 4
) (
  input  logic                clk_in,
  input  logic                reset,
  framebuffer_store_if.slave  bus,
  output logic [1:0]          fsm_state
);

  localparam int AW = 1 + ROW_BITS + COLUMN_BITS;
  localparam logic [AW-1:0] LAST_INDEX = {AW{1'b1}};

  typedef enum logic [1:0] {
    ST_HIGH  = 2'd0,
    ST_LOW   = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] pixel_index;
  logic [15:0]   data;
  logic          accept;
  logic          in_write;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= ST_HIGH;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. frame_start outside ST_WRITE drops any half-assembled
  // pixel; inside ST_WRITE the pending write finishes first.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_HIGH: begin
        if (bus.frame_start)  state_next = ST_HIGH;
        else if (accept)      state_next = ST_LOW;
      end
      ST_LOW: begin
        if (bus.frame_start)  state_next = ST_HIGH;
        else if (accept)      state_next = ST_WRITE;
      end
      ST_WRITE: state_next = ST_HIGH;
      default:  state_next = ST_HIGH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. The write strobe is decoded from the state register, so an
  // asynchronous reset removes it immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_write             = (state == ST_WRITE);
    bus.byte_ready       = !reset && !in_write && !bus.frame_start;
    bus.ram_write_enable = in_write;
    bus.ram_clk_enable   = in_write;
    bus.frame_done       = in_write && (pixel_index == LAST_INDEX);
  end

  assign accept = bus.byte_valid && bus.byte_ready;

  // ---------------------------------------------------------------------------
  // Datapath: pixel pointer and byte assembly register.
  // The pointer only moves at the end of ST_WRITE, which keeps the address
  // stable for the whole write cycle. Natural overflow wraps 2047 -> 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pixel_index <= '0;
      data        <= '0;
    end else if (state == ST_WRITE) begin
      if (bus.frame_start) pixel_index <= '0;
      else                 pixel_index <= pixel_index + 1'b1;
    end else if (bus.frame_start) begin
      pixel_index <= '0;
    end else if (accept) begin
`ifdef FRAMEBUFFER_STORE_LITTLE_ENDIAN_EN
      if (state == ST_HIGH) data[7:0]  <= bus.byte_in;
      else                  data[15:8] <= bus.byte_in;
`else
      if (state == ST_HIGH) data[15:8] <= bus.byte_in;
      else                  data[7:0]  <= bus.byte_in;
`endif
    end
  end

  // Column field is inverted so the fetch path can scan columns downwards.
  assign bus.ram_address  = {pixel_index[AW-1],
                             pixel_index[AW-2:COLUMN_BITS],
                             ~pixel_index[COLUMN_BITS-1:0]};
  assign bus.ram_data_out = data;
  assign bus.ram_reset    = reset;
  assign bus.pixel_index  = pixel_index;
  assign fsm_state        = state;

endmodule

// File: tb/tb_framebuffer_store.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_store
//
// Directed bench for framebuffer_store. Drivers push the expected RAM write
// {address, data, frame_done} into exp_q; a monitor on the falling edge pops
// and compares each write strobe. Phase checks cover reset values, pointer
// state, address boundaries, frame_start and reset-during-write.
// -----------------------------------------------------------------------------
module tb_framebuffer_store;

  logic       clk_in = 1'b0;
  logic       reset;
  logic [1:0] fsm_state;

  framebuffer_store_if bus ();

  framebuffer_store dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  // Scoreboard state
  logic [27:0] exp_q[$];
  logic [10:0] wr_addr_log[$];
  logic [27:0] exp_e;
  logic [10:0] exp_idx = '0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          fd_count = 0;
  int          rdy_low = 0;
  bit          count_en = 1'b0;
  logic [15:0] v;

  function automatic logic [10:0] map_addr(input logic [10:0] idx);
    return {idx[10], idx[9:6], ~idx[5:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk_in) begin
    if (!reset && bus.ram_write_enable) begin
      wr_addr_log.push_back(bus.ram_address);
      if (bus.frame_done) fd_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty queue",
                 bus.ram_address, bus.ram_data_out);
      end else begin
        exp_e = exp_q.pop_front();
        check("write", {4'b0, bus.ram_address, bus.ram_data_out, bus.frame_done}, {4'b0, exp_e});
        check("write_clk_en", {31'b0, bus.ram_clk_enable}, 32'd1);
      end
    end
    if (!reset && bus.frame_done && !bus.ram_write_enable) begin
      n_checks++;
      $display("FAIL frame_done_alone: frame_done 1 without write strobe");
    end
    if (count_en && !bus.byte_ready) rdy_low++;
  end

  // Drivers (called at a falling edge, return at a falling edge)
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    #1;
    while (!bus.byte_ready && waited < 100) begin
      @(negedge clk_in);
      #1;
      waited++;
    end
    if (waited >= 100) begin
      n_checks++;
      $display("FAIL byte_timeout: byte_ready 0 for %0d cycles, required 1", waited);
      bus.byte_valid = 1'b0;
      return;
    end
    @(negedge clk_in);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] first, input logic [7:0] second);
    logic [15:0] d;
`ifdef FRAMEBUFFER_STORE_LITTLE_ENDIAN_EN
    d = {second, first};
`else
    d = {first, second};
`endif
    exp_q.push_back({map_addr(exp_idx), d, exp_idx == 11'h7FF});
    exp_idx = exp_idx + 1'b1;
    send_byte(first);
    send_byte(second);
  endtask

  task automatic pulse_frame_start();
    bus.frame_start = 1'b1;
    @(negedge clk_in);
    bus.frame_start = 1'b0;
    exp_idx = '0;
  endtask

  // Stimulus
  initial begin
    bus.byte_in     = 8'h00;
    bus.byte_valid  = 1'b0;
    bus.frame_start = 1'b0;
    reset           = 1'b1;
    #1;
    check("ram_reset_high", {31'b0, bus.ram_reset}, 32'd1);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    #1;
    check("rst_address", {21'b0, bus.ram_address}, 32'h03F);
    check("rst_data", {16'b0, bus.ram_data_out}, 32'h0);
    check("rst_we", {31'b0, bus.ram_write_enable}, 32'd0);
    check("rst_ce", {31'b0, bus.ram_clk_enable}, 32'd0);
    check("rst_frame_done", {31'b0, bus.frame_done}, 32'd0);
    check("rst_ready", {31'b0, bus.byte_ready}, 32'd1);
    check("rst_index", {21'b0, bus.pixel_index}, 32'd0);
    check("rst_ram_reset", {31'b0, bus.ram_reset}, 32'd0);
    @(negedge clk_in);

    // First pixel
    send_pixel(8'hF8, 8'h00);
    @(negedge clk_in);
    check("p1_index", {21'b0, bus.pixel_index}, 32'd1);
    check("p1_no_frame_done", fd_count, 32'd0);

    // 65 pixels from index 0, data = index
    pulse_frame_start();
    wr_addr_log.delete();
    rdy_low  = 0;
    count_en = 1'b1;
    for (int i = 0; i < 65; i++) begin
      v = i[15:0];
      send_pixel(v[15:8], v[7:0]);
    end
    @(negedge clk_in);
    count_en = 1'b0;
    check("s65_ready_low", rdy_low, 32'd65);
    check("s65_writes", wr_addr_log.size(), 32'd65);
    check("s65_addr1", {21'b0, wr_addr_log[1]}, 32'h03E);
    check("s65_addr63", {21'b0, wr_addr_log[63]}, 32'h000);
    check("s65_addr64", {21'b0, wr_addr_log[64]}, 32'h07F);
    check("s65_index", {21'b0, bus.pixel_index}, 32'd65);

    // Full frame
    pulse_frame_start();
    wr_addr_log.delete();
    fd_count = 0;
    for (int i = 0; i < 2048; i++) begin
      v = i[15:0] ^ 16'h5A3C;
      send_pixel(v[15:8], v[7:0]);
    end
    @(negedge clk_in);
    check("frame_done_count", fd_count, 32'd1);
    check("frame_addr1024", {21'b0, wr_addr_log[1024]}, 32'h43F);
    check("frame_addr2047", {21'b0, wr_addr_log[2047]}, 32'h7C0);
    check("frame_index_wrap", {21'b0, bus.pixel_index}, 32'd0);

    // frame_start while half a pixel is held, with a byte presented
    wr_addr_log.delete();
    send_byte(8'hAA);
    bus.byte_in     = 8'h55;
    bus.byte_valid  = 1'b1;
    bus.frame_start = 1'b1;
    #1;
    check("fs_ready_forced_low", {31'b0, bus.byte_ready}, 32'd0);
    @(negedge clk_in);
    bus.frame_start = 1'b0;
    bus.byte_valid  = 1'b0;
    exp_idx = '0;
    check("fs_state_high", {30'b0, fsm_state}, 32'd0);
    send_pixel(8'h12, 8'h34);
    @(negedge clk_in);
    check("fs_single_write", wr_addr_log.size(), 32'd1);
    check("fs_write_addr", {21'b0, wr_addr_log[0]}, 32'h03F);

    // frame_start during the write of pixel 5
    pulse_frame_start();
    wr_addr_log.delete();
    for (int i = 0; i < 5; i++) send_pixel(8'h40, i[7:0]);
    send_pixel(8'hBE, 8'hEF);
    check("fsw_in_write", {30'b0, fsm_state}, 32'd2);
    bus.frame_start = 1'b1;
    @(negedge clk_in);
    bus.frame_start = 1'b0;
    exp_idx = '0;
    check("fsw_index", {21'b0, bus.pixel_index}, 32'd0);
    send_pixel(8'h11, 8'h22);
    @(negedge clk_in);
    check("fsw_addr5", {21'b0, wr_addr_log[5]}, 32'h03A);
    check("fsw_next_addr", {21'b0, wr_addr_log[6]}, 32'h03F);

    // Reset asserted in the middle of a write cycle
    send_byte(8'h77);
    bus.byte_in    = 8'h88;
    bus.byte_valid = 1'b1;
    @(posedge clk_in);
    #2;
    bus.byte_valid = 1'b0;
    check("rw_write_started", {31'b0, bus.ram_write_enable}, 32'd1);
    reset = 1'b1;
    #1;
    check("rw_we_drop", {31'b0, bus.ram_write_enable}, 32'd0);
    check("rw_ce_drop", {31'b0, bus.ram_clk_enable}, 32'd0);
    check("rw_address", {21'b0, bus.ram_address}, 32'h03F);
    check("rw_data", {16'b0, bus.ram_data_out}, 32'h0);
    check("rw_frame_done", {31'b0, bus.frame_done}, 32'd0);
    check("rw_index", {21'b0, bus.pixel_index}, 32'd0);
    check("rw_ram_reset", {31'b0, bus.ram_reset}, 32'd1);
    @(negedge clk_in);
    reset = 1'b0;
    exp_idx = '0;
    @(negedge clk_in);
    wr_addr_log.delete();
    send_pixel(8'h9A, 8'hBC);
    @(negedge clk_in);
    check("rw_first_addr", {21'b0, wr_addr_log[0]}, 32'h03F);

    repeat (3) @(negedge clk_in);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/framebuffer_store.md
# framebuffer_store

Writer side of the LED panel framebuffer RAM: accepts a byte stream of RGB565 pixels, assembles 16-bit words and writes them in the exact address layout the display fetch path reads from. Each address is `{half, row, ~column}`: half 0 holds the top panel half and half 1 the bottom, and the column field is inverted. Sits between the host byte source (UART/SPI receiver) and the write port of the dual-port framebuffer RAM. All logic runs on `posedge clk_in`.

## Interface
- `COLUMN_BITS`, default 6: column field width, giving 64 columns.
- `ROW_BITS`, default 4: row field width, giving 16 rows per half.
- `clk_in`, input, 1: system clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `byte_in`, input, 8: incoming data byte.
- `byte_valid`, input, 1: `byte_in` is valid this cycle.
- `byte_ready`, output, 1: block can accept a byte this cycle.
- `frame_start`, input, 1: synchronous restart of the write pointer at pixel 0.
- `ram_address`, output, 1+ROW_BITS+COLUMN_BITS (11): RAM write address.
- `ram_data_out`, output, 16: RGB565 word to write.
- `ram_write_enable`, output, 1: write strobe.
- `ram_clk_enable`, output, 1: RAM write-port clock enable.
- `ram_reset`, output, 1: equals `reset`.
- `frame_done`, output, 1: one-cycle pulse when the last pixel of a frame is written.
- `pixel_index`, output, 11: index of the next pixel to be written.

## Operation
- The pixel pointer `pixel_index` is 11 bits (2048 pixels). It decomposes as `half = idx[10]`, `row = idx[9:6]`, `col = idx[5:0]`.
- `ram_address = {half, row, ~col}`. Index 0 maps to 0x03F; index 2047 maps to 0x7C0.
- A byte is accepted on a clock edge where `byte_valid && byte_ready`.
- State machine:
  - ST_HIGH: waiting for byte 0. On accept, latch it into `data[15:8]` and go to ST_LOW.
  - ST_LOW: waiting for byte 1. On accept, latch it into `data[7:0]` and go to ST_WRITE.
  - ST_WRITE: single cycle. Go to ST_HIGH and increment `pixel_index`. Index 2047 wraps to 0.
- `byte_ready` is 1 in ST_HIGH and ST_LOW, and 0 in ST_WRITE.
- `ram_write_enable` and `ram_clk_enable` are 1 only in ST_WRITE.
- `ram_address` and `ram_data_out` are stable throughout ST_WRITE.
- `frame_done` is 1 in the ST_WRITE cycle when `pixel_index == 2047`.
- `frame_start` behaviour by state:
  - In ST_HIGH or ST_LOW: `pixel_index` clears to 0, the state goes to ST_HIGH, and any half-assembled byte is discarded. A byte presented in the same cycle is not accepted: `byte_ready` is forced to 0 that cycle.
  - In ST_WRITE: the pending write completes at the current address (and `frame_done` still fires if the index is 2047). Then `pixel_index` is 0 and the state is ST_HIGH.
- Reset values: state ST_HIGH, `pixel_index` 0, data register 0, `ram_address` 0x03F, `ram_data_out` 0, `ram_write_enable` 0, `ram_clk_enable` 0, `frame_done` 0, `byte_ready` 1 after release.
- Reset asserted mid-write aborts the write immediately, because the write enable is asynchronously cleared.

## Timing
- Throughput is one pixel per 3 cycles minimum: byte, byte, write.
- Latency: the write strobe is asserted in the cycle following acceptance of the second byte.
- Back-to-back bytes are accepted with no bubble between byte 0 and byte 1. The source must hold a byte while `byte_ready` is 0.
- `byte_valid` gaps of any length are allowed in ST_HIGH and ST_LOW; state is held.

## Configuration
- `FRAMEBUFFER_STORE_LITTLE_ENDIAN_EN`:
  - Defined: the first byte of each pixel goes to `data[7:0]` and the second to `data[15:8]`.
  - Undefined (default): the first byte is the high byte (big-endian).
  - All other behaviour is identical.

## Test plan
- After reset, send bytes 0xF8, 0x00:
  - One write strobe with address 0x03F and data 0xF800 (0x00F8 with the macro defined).
  - `pixel_index` becomes 1; no `frame_done`.
- Stream 65 pixels with data equal to the index:
  - Pixel 1 is written to 0x03E, pixel 63 to 0x000, and pixel 64 to 0x07F.
  - `byte_ready` is low exactly one cycle per pixel.
- Stream 2048 pixels:
  - Pixel 1024 is written to 0x43F and pixel 2047 to 0x7C0.
  - `frame_done` pulses once, coincident with that write; `pixel_index` then reads 0.
- Send 0xAA, then pulse `frame_start` with `byte_valid` high, then send 0x12, 0x34:
  - 0xAA is discarded and the byte in the `frame_start` cycle is not accepted.
  - A single write of 0x1234 occurs to 0x03F.
- Assert `frame_start` during ST_WRITE at index 5:
  - The write to 0x03A completes; the next pixel is written to 0x03F.
- Assert `reset` during ST_WRITE:
  - `ram_write_enable` drops immediately and all outputs return to their reset values.
  - After release, the first pixel is written to 0x03F.
